// File: rtl/logic_result_stage.sv
// logic_result_stage: selects the opcode-named logicUnit result and queues it
// in a small handshaked FIFO, with zero/illegal tags, op counter and sticky error.
module logic_result_stage #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [2:0]       i_op_code,
    input  logic [WIDTH-1:0] i_result_a,
    input  logic [WIDTH-1:0] i_result_o,
    input  logic [WIDTH-1:0] i_result_x,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic [2:0]       o_out_op,
    output logic             o_out_zero,
    output logic             o_out_illegal,
    input  logic             i_clear_err,
    output logic             o_err_sticky,
    output logic [CNT_W-1:0] o_op_count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem_data [DEPTH];
    logic [2:0]       r_mem_op   [DEPTH];
    logic             r_mem_ill  [DEPTH];
    logic [AW-1:0]    r_wr, r_rd;
    logic [AW:0]      r_occ;
    logic [WIDTH-1:0] r_out_data;
    logic [2:0]       r_out_op;
    logic             r_out_zero, r_out_ill, r_err;
    logic [CNT_W-1:0] r_cnt;
    logic             w_push, w_pop, w_legal, w_load_in, w_load_mem;
    logic [WIDTH-1:0] w_sel;
    logic [AW-1:0]    w_rd_nxt;
    assign o_in_ready  = r_occ < (AW+1)'(DEPTH);
    assign o_out_valid = r_occ != '0;
    assign w_push      = i_in_valid && o_in_ready;
    assign w_pop       = o_out_valid && i_out_ready;
    assign w_legal     = i_op_code == 3'b001 || i_op_code == 3'b010 || i_op_code == 3'b100;
    assign w_sel       = i_op_code == 3'b001 ? i_result_a :
                         i_op_code == 3'b010 ? i_result_o :
                         i_op_code == 3'b100 ? i_result_x : '0;
    assign w_rd_nxt    = r_rd + AW'(1);
    // The head is held in its own registers so it keeps its last value once empty.
    assign w_load_in   = w_push && (r_occ == '0 || (w_pop && r_occ == (AW+1)'(1)));
    assign w_load_mem  = w_pop && r_occ > (AW+1)'(1);
    assign o_out_data    = r_out_data;
    assign o_out_op      = r_out_op;
    assign o_out_zero    = r_out_zero;
    assign o_out_illegal = r_out_ill;
    assign o_err_sticky  = r_err;
    assign o_op_count    = r_cnt;
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr] <= w_sel;
            r_mem_op[r_wr]   <= i_op_code;
            r_mem_ill[r_wr]  <= !w_legal;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_occ      <= '0;
            r_out_data <= '0;
            r_out_op   <= '0;
            r_out_zero <= 1'b0;
            r_out_ill  <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= w_rd_nxt;
            r_occ <= r_occ + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (w_load_in) begin
                r_out_data <= w_sel;
                r_out_op   <= i_op_code;
                r_out_zero <= w_sel == '0;
                r_out_ill  <= !w_legal;
            end else if (w_load_mem) begin
                r_out_data <= r_mem_data[w_rd_nxt];
                r_out_op   <= r_mem_op[w_rd_nxt];
                r_out_zero <= r_mem_data[w_rd_nxt] == '0;
                r_out_ill  <= r_mem_ill[w_rd_nxt];
            end
            if (w_push && !w_legal) r_err <= 1'b1;
            else if (i_clear_err) r_err <= 1'b0;
            if (w_push && w_legal && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_logic_result_stage.sv
// tb_logic_result_stage: directed vectors with hand-computed expectations for
// logic_result_stage, plus a CNT_W=3 instance sharing the stimulus for saturation.
module tb_logic_result_stage;
    logic       clk = 0, rst = 1;
    logic       in_valid = 0, out_ready = 0, clear_err = 0;
    logic [2:0] op_code = 0;
    logic [3:0] res_a = 0, res_o = 0, res_x = 0;
    logic       in_ready, out_valid, out_zero, out_illegal, err_sticky;
    logic [3:0] out_data;
    logic [2:0] out_op;
    logic [7:0] op_count;
    logic       s_in_ready, s_out_valid, s_out_zero, s_out_illegal, s_err_sticky;
    logic [3:0] s_out_data;
    logic [2:0] s_out_op;
    logic [2:0] s_op_count;
    int         n_chk = 0, n_fail = 0;
    logic [3:0] exp_d;

    always #5 clk = ~clk;

    logic_result_stage dut (
        .clk(clk), .rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_op_code(op_code), .i_result_a(res_a), .i_result_o(res_o), .i_result_x(res_x),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
        .o_out_op(out_op), .o_out_zero(out_zero), .o_out_illegal(out_illegal),
        .i_clear_err(clear_err), .o_err_sticky(err_sticky), .o_op_count(op_count)
    );

    logic_result_stage #(.CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .i_in_valid(in_valid), .o_in_ready(s_in_ready),
        .i_op_code(op_code), .i_result_a(res_a), .i_result_o(res_o), .i_result_x(res_x),
        .o_out_valid(s_out_valid), .i_out_ready(out_ready), .o_out_data(s_out_data),
        .o_out_op(s_out_op), .o_out_zero(s_out_zero), .o_out_illegal(s_out_illegal),
        .i_clear_err(clear_err), .o_err_sticky(s_err_sticky), .o_op_count(s_op_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3;
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 1);
        check("rst_data", out_data, 0);
        check("rst_op", out_op, 0);
        check("rst_zero", out_zero, 0);
        check("rst_ill", out_illegal, 0);
        check("rst_err", err_sticky, 0);
        check("rst_cnt", op_count, 0);
        tick();
        rst = 0;
        // single AND
        op_code = 3'b001; res_a = 4'b0001; res_o = 4'b0011; res_x = 4'b0010; in_valid = 1;
        tick();
        in_valid = 0;
        check("and_valid", out_valid, 1);
        check("and_data", out_data, 4'b0001);
        check("and_op", out_op, 3'b001);
        check("and_zero", out_zero, 0);
        check("and_ill", out_illegal, 0);
        check("and_cnt", op_count, 1);
        out_ready = 1;
        tick();
        out_ready = 0;
        check("empty_valid", out_valid, 0);
        check("empty_hold", out_data, 4'b0001);
        // fill to full with consumer stalled
        op_code = 3'b010; res_o = 4'b1101; in_valid = 1;
        tick();
        op_code = 3'b100; res_x = 4'b0000;
        tick();
        check("full_ready", in_ready, 0);
        check("full_head", out_data, 4'b1101);
        op_code = 3'b001; res_a = 4'b0111;
        tick();
        in_valid = 0;
        check("full_ign_cnt", op_count, 3);
        check("full_ign_ready", in_ready, 0);
        check("full_stable", out_data, 4'b1101);
        check("full_stable_op", out_op, 3'b010);
        out_ready = 1;
        tick();
        check("drain2_valid", out_valid, 1);
        check("drain2_data", out_data, 4'b0000);
        check("drain2_op", out_op, 3'b100);
        check("drain2_zero", out_zero, 1);
        check("drain_ready", in_ready, 1);
        tick();
        out_ready = 0;
        check("drained_valid", out_valid, 0);
        // illegal op and sticky error
        op_code = 3'b011; res_a = 4'b1111; res_o = 4'b1111; res_x = 4'b1111; in_valid = 1;
        tick();
        in_valid = 0;
        check("ill_data", out_data, 0);
        check("ill_flag", out_illegal, 1);
        check("ill_zero", out_zero, 1);
        check("ill_op", out_op, 3'b011);
        check("ill_err", err_sticky, 1);
        check("ill_cnt", op_count, 3);
        out_ready = 1;
        tick();
        out_ready = 0;
        clear_err = 1;
        tick();
        clear_err = 0;
        check("clr_err", err_sticky, 0);
        clear_err = 1; op_code = 3'b000; in_valid = 1;
        tick();
        clear_err = 0; in_valid = 0;
        check("clr_vs_set", err_sticky, 1);
        check("clr_vs_set_cnt", op_count, 3);
        // streaming from a clean state
        #2 rst = 1;
        #2 rst = 0;
        check("rst2_cnt", op_count, 0);
        out_ready = 1; in_valid = 1;
        for (int k = 0; k < 20; k++) begin
            op_code = 3'(1 << (k % 3));
            res_a = 4'(k); res_o = 4'(k + 5); res_x = 4'(k + 9);
            exp_d = (k % 3 == 0) ? 4'(k) : (k % 3 == 1) ? 4'(k + 5) : 4'(k + 9);
            tick();
            check($sformatf("strm_valid%0d", k), out_valid, 1);
            check($sformatf("strm_data%0d", k), out_data, exp_d);
        end
        in_valid = 0;
        tick();
        check("strm_cnt", op_count, 20);
        check("strm_empty", out_valid, 0);
        check("sat_cnt_strm", s_op_count, 7);
        // saturation on the CNT_W=3 instance
        #2 rst = 1;
        #2 rst = 0;
        in_valid = 1; op_code = 3'b010; res_o = 4'b0110;
        for (int k = 0; k < 10; k++) tick();
        in_valid = 0;
        tick();
        check("sat_cnt", s_op_count, 7);
        check("unsat_cnt", op_count, 10);
        // async reset while full
        out_ready = 0; op_code = 3'b110; in_valid = 1;
        tick();
        op_code = 3'b001; res_a = 4'b0101;
        tick();
        in_valid = 0;
        check("pre_rst_ready", in_ready, 0);
        check("pre_rst_err", err_sticky, 1);
        #2 rst = 1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_ready", in_ready, 1);
        check("arst_cnt", op_count, 0);
        check("arst_err", err_sticky, 0);
        check("arst_data", out_data, 0);
        tick();
        rst = 0;
        op_code = 3'b010; res_o = 4'b1001; in_valid = 1;
        tick();
        in_valid = 0;
        check("post_rst_valid", out_valid, 1);
        check("post_rst_data", out_data, 4'b1001);
        check("post_rst_cnt", op_count, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/logic_result_stage.md
Name: logic_result_stage

Overview:
Downstream stage of logicUnit. Consumes its three parallel results (resultA, resultO, resultX) plus the one-hot opCode that produced them, and selects the result the opcode names. Buffers selected results in a small FIFO with valid/ready handshakes on both sides, and tags each entry with zero and illegal-opcode flags. Also keeps an accepted-operation counter and a sticky error bit for the control block.

Parameters:
WIDTH, 4, data width of resultA/resultO/resultX and outData
DEPTH, 2, FIFO entries (power of two, >= 2)
CNT_W, 8, width of opCount

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
inValid  input  1  upstream has a result set this cycle
inReady  output  1  stage can accept this cycle
opCode  input  3  one-hot op: 001 AND, 010 OR, 100 XOR
resultA  input  WIDTH  AND result from logicUnit
resultO  input  WIDTH  OR result from logicUnit
resultX  input  WIDTH  XOR result from logicUnit
outValid  output  1  head entry valid
outReady  input  1  consumer takes head this cycle
outData  output  WIDTH  selected result of head entry
outOp  output  3  opCode of head entry
outZero  output  1  head outData == 0
outIllegal  output  1  head entry had an illegal opCode
clearErr  input  1  synchronous clear of errSticky
errSticky  output  1  set when any illegal opCode is accepted
opCount  output  CNT_W  number of accepted legal ops, saturating

Behaviour:
- Reset (async, any time, incl. mid-transfer):
  - FIFO emptied.
  - outValid=0, inReady=1, outData=0, outOp=0, outZero=0, outIllegal=0, errSticky=0, opCount=0.
- Select (combinational on input side):
  - 001 -> resultA; 010 -> resultO; 100 -> resultX.
  - Any other code (000, 011, 101, 110, 111) -> data 0, illegal=1.
  - zero = (selected data == 0); illegal entries therefore also carry zero=1.
- Push when inValid && inReady. Entry {data, opCode, zero, illegal} written at that rising edge.
- Pop when outValid && outReady. Head advances at that rising edge.
- Latency:
  - Push into empty FIFO -> outValid=1 with that entry on the next cycle.
  - No combinational path from input data to outputs.
- inReady = (occupancy < DEPTH). Registered/occupancy-derived only; never depends on outReady in the same cycle.
- outValid = (occupancy != 0). Head fields are stable while outValid && !outReady.
- Full: inReady=0, so no push. A pop that cycle frees a slot; inReady=1 the following cycle.
- Empty: outValid=0; outData/outOp/outZero/outIllegal hold their last values (0 after reset).
- Simultaneous push and pop with 0 < occupancy < DEPTH: occupancy unchanged, order preserved.
- Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
- opCount:
  - +1 on each push with a legal opCode.
  - Saturates at 2^CNT_W-1; illegal pushes do not count.
- errSticky:
  - Set on any push with illegal=1.
  - clearErr clears it at the clock edge.
  - If clearErr and an illegal push occur in the same cycle, set wins (errSticky=1).
- inValid while inReady=0: no state change. Upstream must hold its data.

Test Plan:
- Reset then single AND: opCode=001, resultA=0001, resultO=0011, resultX=0010, inValid 1 cycle -> next cycle outValid=1, outData=0001, outOp=001, outZero=0, opCount=1.
- Fill with outReady=0: push OR (resultO=1101), then XOR (resultX=0000) -> inReady=0 after 2 pushes. Third inValid ignored. Then outReady=1 drains 1101 then 0000 (outZero=1) in order; inReady returns to 1.
- Illegal op: opCode=011 pushed -> outData=0000, outIllegal=1, outZero=1, errSticky=1, opCount unchanged. clearErr=1 alone -> errSticky=0. clearErr with another illegal push (opCode=000) in the same cycle -> errSticky stays 1.
- Streaming: inValid=1 and outReady=1 for 20 cycles, alternating ops 001/010/100 -> one output per cycle in input order, no drops, opCount=20.
- Saturation: with CNT_W=3, push 10 legal ops -> opCount=7.
- Async reset mid-operation: assert rst between clock edges with FIFO full -> immediately outValid=0, inReady=1, opCount=0, errSticky=0. After release, the first push appears one cycle later.
